// File: rtl/fifo_flow_pkg.sv
// ---------------------------------------------------------------------------
// fifo_flow_pkg
// Shared definitions for the multi-channel FIFO flow-control FSM.
//   STATE_W      : width of the FSM state code exposed on the 'state' port
//   fsm_state_e  : FSM state codes
//                  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
//                  Codes 5..7 are illegal and recover to RESET.
// ---------------------------------------------------------------------------
package fifo_flow_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] S_INIT   = 3'd1;
  localparam logic [STATE_W-1:0] S_IDLE   = 3'd2;
  localparam logic [STATE_W-1:0] S_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] S_ERROR  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = S_RESET,
    ST_INIT   = S_INIT,
    ST_IDLE   = S_IDLE,
    ST_ACTIVE = S_ACTIVE,
    ST_ERROR  = S_ERROR
  } fsm_state_e;

endpackage

// File: rtl/fifo_flow_ctrl_fsm_hyst.sv
// ---------------------------------------------------------------------------
// flow_hyst_ch
// One channel of pause hysteresis: a single flop that the FSM can set,
// clear, force high or clear unconditionally.
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset (pause -> 0)
//   set_i        : almost-full seen while the channel is being regulated
//   clr_i        : almost-empty seen while the channel is being regulated
//   force_i      : drive pause high (error handling)
//   clear_all_i  : drive pause low (configuration / return to idle)
//   pause_o      : registered pause request for this channel
// Priority: clear_all_i > force_i > set_i > clr_i > hold.
// ---------------------------------------------------------------------------
module flow_hyst_ch (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  input  logic force_i,
  input  logic clear_all_i,
  output logic pause_o
);

  logic pause_q;
  logic pause_d;

  // Set beats clear so a FIFO that reports both almost-full and
  // almost-empty (tiny threshold window) errs on the side of stalling.
  always_comb begin
    pause_d = pause_q;
    if (clear_all_i) begin
      pause_d = 1'b0;
    end else if (force_i) begin
      pause_d = 1'b1;
    end else if (set_i) begin
      pause_d = 1'b1;
    end else if (clr_i) begin
      pause_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause_d;
    end
  end

  assign pause_o = pause_q;

endmodule

// File: rtl/fifo_flow_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// fifo_flow_ctrl_fsm
// Flow-control FSM serving a bank of NUM_CH FIFOs. Programs shared
// almost-full / almost-empty thresholds during INIT, regulates per-channel
// source pause with hysteresis while ACTIVE, and records sticky overflow
// errors plus a data snapshot from the lowest-index overflowing channel.
//   clk, reset          : clock, asynchronous active-high reset
//   init                : level-sensitive configuration request
//   thr_af_in/thr_ae_in : thresholds to program while init is high
//   fifo_empty          : per-channel empty flags
//   fifo_almost_full    : per-channel almost-full flags
//   fifo_almost_empty   : per-channel almost-empty flags
//   fifo_overflow       : per-channel write-while-full pulses
//   data_snap           : per-channel head data, ch i at [i*DATA_W +: DATA_W]
//   thr_af/thr_ae       : active thresholds broadcast to the FIFOs
//   pause               : per-channel source stall request
//   error_full          : sticky per-channel overflow flags
//   err_data            : snapshot from the first error event
//   state/idle/active   : FSM state code and decodes
//   cfg_error           : last programmed thresholds were invalid
// All outputs come from flops; idle/active are decodes of the state flop.
// ---------------------------------------------------------------------------
module fifo_flow_ctrl_fsm
  import fifo_flow_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DEPTH_W = 3,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [DEPTH_W-1:0]       thr_af_in,
  input  logic [DEPTH_W-1:0]       thr_ae_in,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH-1:0]        fifo_almost_full,
  input  logic [NUM_CH-1:0]        fifo_almost_empty,
  input  logic [NUM_CH-1:0]        fifo_overflow,
  input  logic [NUM_CH*DATA_W-1:0] data_snap,
  output logic [DEPTH_W-1:0]       thr_af,
  output logic [DEPTH_W-1:0]       thr_ae,
  output logic [NUM_CH-1:0]        pause,
  output logic [NUM_CH-1:0]        error_full,
  output logic [DATA_W-1:0]        err_data,
  output logic [STATE_W-1:0]       state,
  output logic                     idle,
  output logic                     active,
  output logic                     cfg_error
);

  fsm_state_e          state_q, state_d;
  logic [DEPTH_W-1:0]  thr_af_q, thr_af_d;
  logic [DEPTH_W-1:0]  thr_ae_q, thr_ae_d;
  logic [NUM_CH-1:0]   error_full_q, error_full_d;
  logic [DATA_W-1:0]   err_data_q, err_data_d;
  logic                cfg_error_q, cfg_error_d;

  logic [NUM_CH-1:0]   hyst_set;
  logic [NUM_CH-1:0]   hyst_clr;
  logic                hyst_force;
  logic                hyst_clear_all;

  logic                any_ovf;
  logic                all_empty;
  logic [DATA_W-1:0]   low_data;

  assign any_ovf   = |fifo_overflow;
  assign all_empty = &fifo_empty;

  // Priority encoder: scanning from the top down lets the lowest set index
  // overwrite last, so simultaneous overflows report the lowest channel.
  always_comb begin
    low_data = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fifo_overflow[i]) begin
        low_data = data_snap[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and register-update logic. init in any operational state
  // wins over overflow and FIFO status. Error capture happens only on the
  // transition into ERROR; while in ERROR only the sticky flags grow.
  always_comb begin
    state_d        = state_q;
    thr_af_d       = thr_af_q;
    thr_ae_d       = thr_ae_q;
    error_full_d   = error_full_q;
    err_data_d     = err_data_q;
    cfg_error_d    = cfg_error_q;
    hyst_set       = '0;
    hyst_clr       = '0;
    hyst_force     = 1'b0;
    hyst_clear_all = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end

      ST_INIT: begin
        hyst_clear_all = 1'b1;
        if (init) begin
          thr_af_d = thr_af_in;
          thr_ae_d = thr_ae_in;
        end else if (thr_ae_q < thr_af_q) begin
          state_d     = ST_IDLE;
          cfg_error_d = 1'b0;
        end else begin
          cfg_error_d = 1'b1;
        end
      end

      ST_IDLE, ST_ACTIVE: begin
        if (init) begin
          state_d        = ST_INIT;
          error_full_d   = '0;
          err_data_d     = '0;
          hyst_clear_all = 1'b1;
        end else if (any_ovf) begin
          state_d      = ST_ERROR;
          error_full_d = fifo_overflow;
          err_data_d   = low_data;
          hyst_force   = 1'b1;
        end else if (state_q == ST_IDLE) begin
          if (!all_empty) begin
            state_d = ST_ACTIVE;
          end
        end else if (all_empty) begin
          state_d        = ST_IDLE;
          hyst_clear_all = 1'b1;
        end else begin
          hyst_set = fifo_almost_full;
          hyst_clr = fifo_almost_empty;
        end
      end

      ST_ERROR: begin
        if (init) begin
          state_d        = ST_INIT;
          error_full_d   = '0;
          err_data_d     = '0;
          hyst_clear_all = 1'b1;
        end else begin
          error_full_d = error_full_q | fifo_overflow;
          hyst_force   = 1'b1;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET;
      thr_af_q     <= '0;
      thr_ae_q     <= '0;
      error_full_q <= '0;
      err_data_q   <= '0;
      cfg_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      thr_af_q     <= thr_af_d;
      thr_ae_q     <= thr_ae_d;
      error_full_q <= error_full_d;
      err_data_q   <= err_data_d;
      cfg_error_q  <= cfg_error_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_hyst
    flow_hyst_ch u_hyst (
      .clk         (clk),
      .reset       (reset),
      .set_i       (hyst_set[g]),
      .clr_i       (hyst_clr[g]),
      .force_i     (hyst_force),
      .clear_all_i (hyst_clear_all),
      .pause_o     (pause[g])
    );
  end

  assign thr_af     = thr_af_q;
  assign thr_ae     = thr_ae_q;
  assign error_full = error_full_q;
  assign err_data   = err_data_q;
  assign cfg_error  = cfg_error_q;
  assign state      = state_q;
  assign idle       = (state_q == ST_IDLE);
  assign active     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_fifo_flow_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_fifo_flow_ctrl_fsm
// Directed bench for fifo_flow_ctrl_fsm with a behavioural reference model
// compared on every falling edge, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_fifo_flow_ctrl_fsm;

  localparam int NCH = 4;
  localparam int DW  = 3;
  localparam int XW  = 8;

  logic            clk;
  logic            reset;
  logic            init;
  logic [DW-1:0]   thr_af_in;
  logic [DW-1:0]   thr_ae_in;
  logic [NCH-1:0]  fifo_empty;
  logic [NCH-1:0]  fifo_almost_full;
  logic [NCH-1:0]  fifo_almost_empty;
  logic [NCH-1:0]  fifo_overflow;
  logic [NCH*XW-1:0] data_snap;
  logic [DW-1:0]   thr_af;
  logic [DW-1:0]   thr_ae;
  logic [NCH-1:0]  pause;
  logic [NCH-1:0]  error_full;
  logic [XW-1:0]   err_data;
  logic [2:0]      state;
  logic            idle;
  logic            active;
  logic            cfg_error;

  int checkCount = 0;
  int passCount  = 0;
  bit cmpEn      = 0;

  // Reference model, kept as plain integers and named states
  int m_state = 0;
  int m_af    = 0;
  int m_ae    = 0;
  int m_cfg   = 0;
  int m_pause = 0;
  int m_ef    = 0;
  int m_ed    = 0;

  fifo_flow_ctrl_fsm #(.NUM_CH(NCH), .DEPTH_W(DW), .DATA_W(XW)) dut (
    .clk               (clk),
    .reset             (reset),
    .init              (init),
    .thr_af_in         (thr_af_in),
    .thr_ae_in         (thr_ae_in),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_overflow     (fifo_overflow),
    .data_snap         (data_snap),
    .thr_af            (thr_af),
    .thr_ae            (thr_ae),
    .pause             (pause),
    .error_full        (error_full),
    .err_data          (err_data),
    .state             (state),
    .idle              (idle),
    .active            (active),
    .cfg_error         (cfg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point used by both the per-cycle compare and the
  // hand-computed literal checks.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Behavioural model: what the controller must do on one clock edge,
  // reasoned from the operating modes rather than from any register layout.
  task automatic modelStep();
    int nextPause;
    int found;
    nextPause = m_pause;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      nextPause = 0;
      if (init) begin
        m_af = int'(thr_af_in);
        m_ae = int'(thr_ae_in);
      end else if (m_ae < m_af) begin
        m_state = 2;
        m_cfg   = 0;
      end else begin
        m_cfg = 1;
      end
    end else if (init) begin
      m_state   = 1;
      nextPause = 0;
      m_ef      = 0;
      m_ed      = 0;
    end else if (m_state == 4) begin
      m_ef      = m_ef | int'(fifo_overflow);
      nextPause = (1 << NCH) - 1;
    end else if (fifo_overflow != 0) begin
      m_state   = 4;
      m_ef      = int'(fifo_overflow);
      nextPause = (1 << NCH) - 1;
      found     = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (found == 0 && fifo_overflow[ch]) begin
          m_ed  = int'(data_snap[ch*XW +: XW]);
          found = 1;
        end
      end
    end else if (m_state == 2) begin
      if (fifo_empty != {NCH{1'b1}}) m_state = 3;
    end else begin
      if (fifo_empty == {NCH{1'b1}}) begin
        m_state   = 2;
        nextPause = 0;
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (fifo_almost_full[ch]) nextPause = nextPause | (1 << ch);
          else if (fifo_almost_empty[ch]) nextPause = nextPause & ~(1 << ch);
        end
      end
    end
    m_pause = nextPause;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_af = 0; m_ae = 0; m_cfg = 0;
      m_pause = 0; m_ef = 0; m_ed = 0;
    end else begin
      modelStep();
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cyc_state",     32'(state),      32'(m_state));
      checkOutput("cyc_thr_af",    32'(thr_af),     32'(m_af));
      checkOutput("cyc_thr_ae",    32'(thr_ae),     32'(m_ae));
      checkOutput("cyc_cfg_error", 32'(cfg_error),  32'(m_cfg));
      checkOutput("cyc_pause",     32'(pause),      32'(m_pause));
      checkOutput("cyc_error_full",32'(error_full), 32'(m_ef));
      checkOutput("cyc_err_data",  32'(err_data),   32'(m_ed));
      checkOutput("cyc_idle",      32'(idle),       32'(m_state == 2));
      checkOutput("cyc_active",    32'(active),     32'(m_state == 3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one input vector and advance one clock edge.
  task automatic applyStimulus(input logic i_init, input logic [DW-1:0] af, input logic [DW-1:0] ae,
                               input logic [NCH-1:0] emp, input logic [NCH-1:0] afl,
                               input logic [NCH-1:0] aem, input logic [NCH-1:0] ovf);
    init              = i_init;
    thr_af_in         = af;
    thr_ae_in         = ae;
    fifo_empty        = emp;
    fifo_almost_full  = afl;
    fifo_almost_empty = aem;
    fifo_overflow     = ovf;
    tick();
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; thr_af_in = '0; thr_ae_in = '0;
    fifo_empty = 4'hF; fifo_almost_full = '0; fifo_almost_empty = '0;
    fifo_overflow = '0;
    data_snap = {8'h77, 8'h3C, 8'hA5, 8'h11};
    tick();
    cmpEn = 1'b1;
    tick();
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_thr_af", 32'(thr_af), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("release_to_init", 32'(state), 32'd1);

    // Valid threshold programming
    applyStimulus(1, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);
    applyStimulus(1, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);
    checkOutput("prog_thr_af", 32'(thr_af), 32'd6);
    checkOutput("prog_thr_ae", 32'(thr_ae), 32'd2);
    checkOutput("prog_state", 32'(state), 32'd2);
    checkOutput("prog_cfg_ok", 32'(cfg_error), 32'd0);

    // Invalid thresholds: ae >= af keeps the FSM in INIT
    applyStimulus(1, 3'd3, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0);
    applyStimulus(1, 3'd3, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0);
    applyStimulus(0, 3'd3, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0);
    checkOutput("bad_cfg_error", 32'(cfg_error), 32'd1);
    checkOutput("bad_cfg_state", 32'(state), 32'd1);
    applyStimulus(0, 3'd3, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0);
    checkOutput("bad_cfg_hold", 32'(state), 32'd1);

    // Recover with valid values
    applyStimulus(1, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);
    checkOutput("recover_state", 32'(state), 32'd2);
    checkOutput("recover_cfg", 32'(cfg_error), 32'd0);

    // IDLE <-> ACTIVE
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'h0);
    checkOutput("to_active_state", 32'(state), 32'd3);
    checkOutput("to_active_flag", 32'(active), 32'd1);
    applyStimulus(0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);
    checkOutput("to_idle_state", 32'(state), 32'd2);
    checkOutput("to_idle_flag", 32'(idle), 32'd1);

    // Pause hysteresis
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'b0100, 4'h0, 4'h0);
    checkOutput("hyst_set", 32'(pause), 32'h4);
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'h0);
    checkOutput("hyst_hold", 32'(pause), 32'h4);
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'b0100, 4'h0);
    checkOutput("hyst_clear", 32'(pause), 32'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'b0010, 4'b0010, 4'h0);
    checkOutput("hyst_set_wins", 32'(pause), 32'h2);

    // Overflow capture with two channels at once
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'b0110);
    checkOutput("ovf_state", 32'(state), 32'd4);
    checkOutput("ovf_error_full", 32'(error_full), 32'h6);
    checkOutput("ovf_err_data", 32'(err_data), 32'hA5);
    checkOutput("ovf_pause", 32'(pause), 32'hF);
    data_snap = {8'h77, 8'h3C, 8'h00, 8'h11};
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'b1000);
    checkOutput("ovf_sticky", 32'(error_full), 32'hE);
    checkOutput("ovf_data_hold", 32'(err_data), 32'hA5);
    applyStimulus(1, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'h0);
    checkOutput("err_init_state", 32'(state), 32'd1);
    checkOutput("err_init_ef", 32'(error_full), 32'h0);
    checkOutput("err_init_ed", 32'(err_data), 32'h0);
    checkOutput("err_init_pause", 32'(pause), 32'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);
    checkOutput("reinit_idle", 32'(state), 32'd2);

    // init beats a simultaneous overflow
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'h0);
    applyStimulus(1, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'b0001);
    checkOutput("init_prio_state", 32'(state), 32'd1);
    checkOutput("init_prio_ef", 32'(error_full), 32'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0);

    // Asynchronous reset in the middle of ACTIVE with pause=0011
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'h0, 4'h0, 4'h0);
    applyStimulus(0, 3'd6, 3'd2, 4'b1011, 4'b0011, 4'h0, 4'h0);
    checkOutput("pre_reset_pause", 32'(pause), 32'h3);
    fifo_almost_full = 4'h0;
    #1 reset = 1'b1;
    #1;
    checkOutput("async_state", 32'(state), 32'd0);
    checkOutput("async_pause", 32'(pause), 32'h0);
    checkOutput("async_thr_af", 32'(thr_af), 32'h0);
    checkOutput("async_thr_ae", 32'(thr_ae), 32'h0);
    checkOutput("async_active", 32'(active), 32'd0);
    #4 reset = 1'b0;
    tick();
    checkOutput("post_reset_init", 32'(state), 32'd1);
    applyStimulus(0, 3'd0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0);
    tick();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
